// File: rtl/mix_pkg.sv
// mix_pkg: types and constants shared by the transmit mixer (mix_tx)
// and its sine/cosine table (sin_cos_lut).
//   iq_t      signed 18-bit baseband sample component
//   trig_t    signed 18-bit sine/cosine value, full scale +/-TRIG_FS
//   dac_t     signed 14-bit DAC sample
//   iq_pair_t one buffered I/Q sample
package mix_pkg;

    typedef logic signed [17:0] iq_t;
    typedef logic signed [17:0] trig_t;
    typedef logic signed [13:0] dac_t;

    typedef struct packed {
        iq_t i;
        iq_t q;
    } iq_pair_t;

    localparam int TRIG_FS = 131071;
    localparam int DAC_MAX = 8191;
    localparam int DAC_MIN = -8192;

endpackage

// File: rtl/mix_tx_sin_cos_lut.sv
// sin_cos_lut: full-cycle sine/cosine table with a 2-cycle registered read.
//   clk, rst  system clock, synchronous active-high reset
//   idx_i     phase index, 2^LUT_AW entries per cycle of 2*pi
//   valid_i   pipeline valid bit travelling with idx_i
//   sin_o     round(TRIG_FS*sin(2*pi*idx/2^LUT_AW)), 2 cycles after idx_i
//   cos_o     round(TRIG_FS*cos(2*pi*idx/2^LUT_AW)), 2 cycles after idx_i
//   valid_o   valid_i delayed by 2 cycles
// Wherever the valid bit is 0, the matching stage holds zero data.
module sin_cos_lut
    import mix_pkg::*;
#(
    parameter int LUT_AW = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LUT_AW-1:0] idx_i,
    input  logic              valid_i,
    output trig_t             sin_o,
    output trig_t             cos_o,
    output logic              valid_o
);

    localparam int  N      = 1 << LUT_AW;
    localparam real TWO_PI = 6.283185307179586;

    trig_t cos_rom [N];
    trig_t sin_rom [N];

    // Table contents are elaboration-time constants; rounding is half away
    // from zero so the quarter points land exactly on 0 and +/-TRIG_FS.
    for (genvar k = 0; k < N; k++) begin : g_rom
        localparam real ANG = TWO_PI * k / N;
        localparam real CR  = $cos(ANG) * TRIG_FS;
        localparam real SR  = $sin(ANG) * TRIG_FS;
        localparam int  CI  = (CR >= 0.0) ? $rtoi(CR + 0.5) : -$rtoi(0.5 - CR);
        localparam int  SI  = (SR >= 0.0) ? $rtoi(SR + 0.5) : -$rtoi(0.5 - SR);
        assign cos_rom[k] = trig_t'(CI);
        assign sin_rom[k] = trig_t'(SI);
    end

    logic [LUT_AW-1:0] idx_q;
    logic              v1_q;
    trig_t             sin_q;
    trig_t             cos_q;
    logic              v2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
            v1_q  <= 1'b0;
            sin_q <= '0;
            cos_q <= '0;
            v2_q  <= 1'b0;
        end else begin
            idx_q <= valid_i ? idx_i : '0;
            v1_q  <= valid_i;
            sin_q <= v1_q ? sin_rom[idx_q] : '0;
            cos_q <= v1_q ? cos_rom[idx_q] : '0;
            v2_q  <= v1_q;
        end
    end

    assign sin_o   = sin_q;
    assign cos_o   = cos_q;
    assign valid_o = v2_q;

endmodule

// File: rtl/mix_tx.sv
// mix_tx: transmit upconverter, dac_data = sat14(round((I*cos - Q*sin) / 2^OUT_SHIFT)).
//   clk, rst       DAC-rate clock, synchronous active-high reset
//   tx_en          transmit enable; 0 drains zeros down the pipeline
//   phi            frequency word added to the phase accumulator each cycle
//   phase_ofs      static phase offset added after the accumulator
//   iq_i, iq_q     signed baseband sample from the interpolator
//   iq_valid       upstream sample valid
//   iq_ready       buffer not full
//   sample_stb     pop the next buffered sample into the hold register
//   clr_underflow  clears the sticky underflow flag
//   dac_data       signed 14-bit DAC sample
//   dac_valid      dac_data was produced with tx_en=1 throughout
//   underflow      sticky: sample_stb arrived with the buffer empty
//
// Handshake: a sample transfers on every rising clk where iq_valid and
// iq_ready are both 1. iq_ready depends only on registered buffer
// occupancy, never on iq_valid or sample_stb, so a pop in the same cycle
// does not open a slot until the next cycle.
//
// Pipeline from accumulator to dac_data: LUT index reg, LUT data reg,
// product reg, difference reg, round/saturate reg (5 cycles). The held
// sample enters at the product stage, so it reaches dac_data in 3 cycles.
module mix_tx
    import mix_pkg::*;
#(
    parameter int LUT_AW    = 10,
    parameter int OUT_SHIFT = 21
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tx_en,
    input  logic [31:0]        phi,
    input  logic [31:0]        phase_ofs,
    input  logic signed [17:0] iq_i,
    input  logic signed [17:0] iq_q,
    input  logic               iq_valid,
    output logic               iq_ready,
    input  logic               sample_stb,
    input  logic               clr_underflow,
    output logic signed [13:0] dac_data,
    output logic               dac_valid,
    output logic               underflow
);

    localparam logic signed [36:0] RND = 37'sd1 <<< (OUT_SHIFT - 1);

    // ---------------- input buffer and zero-order hold ----------------
    iq_pair_t   buf_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] cnt_q;
    logic [1:0] cnt_d;
    iq_pair_t   held_q;
    logic       underflow_q;
    logic       push;
    logic       pop;
    logic       starve;

    assign iq_ready = (cnt_q != 2'd2);
    assign push     = iq_valid && iq_ready;
    assign pop      = sample_stb && (cnt_q != 2'd0);
    assign starve   = sample_stb && (cnt_q == 2'd0);
    assign cnt_d    = cnt_q + 2'(push) - 2'(pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q[0]    <= '0;
            buf_q[1]    <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            cnt_q       <= 2'd0;
            held_q      <= '0;
            underflow_q <= 1'b0;
        end else begin
            if (push) begin
                buf_q[wr_ptr_q] <= '{i: iq_i, q: iq_q};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                held_q   <= buf_q[rd_ptr_q];
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_d;
            // A new underflow event takes priority over a clear.
            if (starve) begin
                underflow_q <= 1'b1;
            end else if (clr_underflow) begin
                underflow_q <= 1'b0;
            end
        end
    end

    assign underflow = underflow_q;

    // ---------------- phase accumulator and LUT ----------------
    logic [31:0]       acc_q;
    logic [LUT_AW-1:0] lut_idx;
    logic [31-LUT_AW:0] theta_frac_unused;
    trig_t             sin_w;
    trig_t             cos_w;
    logic              trig_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_q + phi;
        end
    end

    // Only the top LUT_AW bits of theta address the table.
    assign {lut_idx, theta_frac_unused} = acc_q + phase_ofs;

    sin_cos_lut #(
        .LUT_AW (LUT_AW)
    ) u_lut (
        .clk     (clk),
        .rst     (rst),
        .idx_i   (lut_idx),
        .valid_i (tx_en),
        .sin_o   (sin_w),
        .cos_o   (cos_w),
        .valid_o (trig_valid)
    );

    // ---------------- multiply, subtract, round/saturate ----------------
    logic signed [35:0] p_i_q;
    logic signed [35:0] p_q_q;
    logic               v3_q;
    logic signed [36:0] sum_q;
    logic               v4_q;
    logic signed [36:0] rnd_sum;
    logic signed [13:0] dac_d;
    logic signed [13:0] dac_q;
    logic               v5_q;

    assign rnd_sum = (sum_q + RND) >>> OUT_SHIFT;

    always_comb begin
        dac_d = rnd_sum[13:0];
        if (rnd_sum > DAC_MAX) begin
            dac_d = dac_t'(DAC_MAX);
        end else if (rnd_sum < DAC_MIN) begin
            dac_d = dac_t'(DAC_MIN);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_i_q <= '0;
            p_q_q <= '0;
            v3_q  <= 1'b0;
            sum_q <= '0;
            v4_q  <= 1'b0;
            dac_q <= '0;
            v5_q  <= 1'b0;
        end else begin
            p_i_q <= trig_valid ? 36'(held_q.i) * 36'(cos_w) : '0;
            p_q_q <= trig_valid ? 36'(held_q.q) * 36'(sin_w) : '0;
            v3_q  <= trig_valid;
            sum_q <= v3_q ? ({p_i_q[35], p_i_q} - {p_q_q[35], p_q_q}) : '0;
            v4_q  <= v3_q;
            dac_q <= v4_q ? dac_d : '0;
            v5_q  <= v4_q;
        end
    end

    assign dac_data  = dac_q;
    assign dac_valid = v5_q;

endmodule

// File: tb/tb_mix_tx.sv
// tb_mix_tx: directed bench for mix_tx. Inputs change 1 time unit after
// each rising edge; outputs are checked at the same point.
module tb_mix_tx;

    logic               clk = 1'b0;
    logic               rst;
    logic               tx_en;
    logic [31:0]        phi;
    logic [31:0]        phase_ofs;
    logic signed [17:0] iq_i;
    logic signed [17:0] iq_q;
    logic               iq_valid;
    logic               iq_ready;
    logic               sample_stb;
    logic               clr_underflow;
    logic signed [13:0] dac_data;
    logic               dac_valid;
    logic               underflow;

    int checks = 0;
    int errors = 0;

    mix_tx #(
        .LUT_AW    (10),
        .OUT_SHIFT (21)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .tx_en         (tx_en),
        .phi           (phi),
        .phase_ofs     (phase_ofs),
        .iq_i          (iq_i),
        .iq_q          (iq_q),
        .iq_valid      (iq_valid),
        .iq_ready      (iq_ready),
        .sample_stb    (sample_stb),
        .clr_underflow (clr_underflow),
        .dac_data      (dac_data),
        .dac_valid     (dac_valid),
        .underflow     (underflow)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int i, input int q);
        iq_valid = 1'b1;
        iq_i     = 18'(i);
        iq_q     = 18'(q);
        step(1);
        iq_valid = 1'b0;
    endtask

    task automatic strobe();
        sample_stb = 1'b1;
        step(1);
        sample_stb = 1'b0;
    endtask

    // ---------------- comparison helpers ----------------
    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input logic signed [31:0] obs,
                              input int exp);
        checks++;
        assert ((obs >= exp - 1) && (obs <= exp + 1)) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d +/-1", tag, obs, exp);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        real e;
        int  ei;
        int  m;

        rst           = 1'b1;
        tx_en         = 1'b0;
        phi           = 32'h0;
        phase_ofs     = 32'h0;
        iq_i          = '0;
        iq_q          = '0;
        iq_valid      = 1'b0;
        sample_stb    = 1'b0;
        clr_underflow = 1'b0;
        step(2);
        rst = 1'b0;

        check("reset_iq_ready", 32'(iq_ready), 1);
        check("reset_dac_data", 32'(dac_data), 0);
        check("reset_dac_valid", 32'(dac_valid), 0);
        check("reset_underflow", 32'(underflow), 0);

        // Phase 0: cos=131071 -> 65536*131071/2^21 rounds to 4096.
        tx_en = 1'b1;
        push(65536, 0);
        strobe();
        step(6);
        check("cos0_dac", 32'(dac_data), 4096);
        check("cos0_valid", 32'(dac_valid), 1);
        step(3);
        check("cos0_steady", 32'(dac_data), 4096);

        // Phase 90 degrees: sin=131071, out = -Q*sin.
        phase_ofs = 32'h4000_0000;
        push(0, 65536);
        strobe();
        step(6);
        check("sin90_qpos", 32'(dac_data), -4096);
        push(0, -65536);
        strobe();
        step(6);
        check("sin90_qneg", 32'(dac_data), 4096);

        // Saturation at both rails.
        phase_ofs = 32'h0;
        push(131071, 0);
        strobe();
        step(6);
        check("sat_pos", 32'(dac_data), 8191);
        push(-131072, 0);
        strobe();
        step(6);
        check("sat_neg", 32'(dac_data), -8192);

        // Handshake: two accepts fill the buffer, the third offer is refused.
        iq_valid = 1'b1;
        iq_i     = 18'(32768);
        iq_q     = 18'(0);
        step(1);
        check("hs_ready_after_1", 32'(iq_ready), 1);
        iq_i = 18'(-32768);
        step(1);
        check("hs_ready_full", 32'(iq_ready), 0);
        iq_i = 18'(131071);
        step(1);
        check("hs_ready_refused", 32'(iq_ready), 0);
        iq_valid = 1'b0;

        // First pop: ready returns, held change reaches dac_data in 3 cycles.
        strobe();
        check("hs_ready_after_pop", 32'(iq_ready), 1);
        step(2);
        check("hold_latency_old", 32'(dac_data), -8192);
        step(1);
        check("hold_latency_new", 32'(dac_data), 2048);

        strobe();
        step(3);
        check("pop2_dac", 32'(dac_data), -2048);
        check("pop2_no_underflow", 32'(underflow), 0);

        // Strobe on an empty buffer: flag set, held sample unchanged.
        strobe();
        check("underflow_set", 32'(underflow), 1);
        step(4);
        check("underflow_dac_hold", 32'(dac_data), -2048);

        clr_underflow = 1'b1;
        step(1);
        clr_underflow = 1'b0;
        check("underflow_clear", 32'(underflow), 0);

        sample_stb    = 1'b1;
        clr_underflow = 1'b1;
        step(1);
        sample_stb    = 1'b0;
        clr_underflow = 1'b0;
        check("underflow_set_wins", 32'(underflow), 1);
        clr_underflow = 1'b1;
        step(1);
        clr_underflow = 1'b0;
        check("underflow_clear2", 32'(underflow), 0);

        // Rotating phase: 4 LUT steps per cycle, 256-cycle period.
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        push(65536, 0);
        strobe();
        step(6);
        check("rot_start", 32'(dac_data), 4096);
        phi = 32'h0100_0000;
        for (int t = 1; t <= 261; t++) begin
            step(1);
            m  = (t >= 5) ? (t - 5) : 0;
            e  = 4096.0 * $cos(6.283185307179586 * m / 256.0);
            ei = (e >= 0.0) ? $rtoi(e + 0.5) : -$rtoi(0.5 - e);
            check_near("rot_cos", 32'(dac_data), ei);
        end

        // tx_en fall and rise both take effect exactly 5 cycles later.
        phi = 32'h0;
        step(8);
        tx_en = 1'b0;
        step(4);
        check("txoff_valid_at4", 32'(dac_valid), 1);
        step(1);
        check("txoff_valid_at5", 32'(dac_valid), 0);
        check("txoff_dac_at5", 32'(dac_data), 0);
        tx_en = 1'b1;
        step(4);
        check("txon_valid_at4", 32'(dac_valid), 0);
        step(1);
        check("txon_valid_at5", 32'(dac_valid), 1);

        // Reset mid-stream with a full buffer.
        iq_valid = 1'b1;
        iq_i     = 18'(1000);
        iq_q     = 18'(2000);
        step(2);
        iq_valid = 1'b0;
        check("pre_rst_full", 32'(iq_ready), 0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("rst_iq_ready", 32'(iq_ready), 1);
        check("rst_dac_data", 32'(dac_data), 0);
        check("rst_dac_valid", 32'(dac_valid), 0);
        check("rst_underflow", 32'(underflow), 0);
        strobe();
        check("rst_buffer_discarded", 32'(underflow), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
